// File: rtl/imm_ext_pkg.sv
// Shared types and elaboration helpers for the immediate-extension pipeline stage.
// Mode encodings are fixed because the ID-stage decoder drives them directly.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        SEXT = 2'd0,
        ZEXT = 2'd1,
        LUI  = 2'd2,
        BOFF = 2'd3
    } imm_mode_e;

    // Legal geometry: 1 <= in_w <= out_w and 0 <= shift < out_w.
    function automatic bit imm_widths_ok(int in_w, int out_w, int shift);
        return (in_w >= 1) && (in_w <= out_w) && (shift >= 0) && (shift < out_w);
    endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle between ID (master) and the immediate-extension stage (slave).
// in_pc/out_target are present only when IMM_BRANCH_TARGET_EN is defined.
interface imm_extend_pipe_if
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    imm_mode_e        in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
`ifdef IMM_BRANCH_TARGET_EN
    logic [OUT_W-1:0] in_pc;
    logic [OUT_W-1:0] out_target;
`endif

    modport master (
`ifdef IMM_BRANCH_TARGET_EN
        output in_pc,
        input  out_target,
`endif
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_imm
    );

    modport slave (
`ifdef IMM_BRANCH_TARGET_EN
        input  in_pc,
        output out_target,
`endif
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_imm
    );
endinterface

// File: rtl/imm_skid_buf.sv
// Two-entry skid buffer: output register (OR) drives the consumer, skid register (SR)
// absorbs one beat of backpressure so in_ready can be a flop instead of a comb path.
module imm_skid_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         or_valid, sr_valid, ready_q;
    logic [W-1:0] or_data, sr_data;
    logic         accept, drain;
    logic         or_valid_nxt, sr_valid_nxt;
    logic         or_load, or_from_sr, sr_load;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        accept       = in_valid && ready_q && !flush;
        drain        = or_valid && out_ready;
        or_valid_nxt = or_valid;
        sr_valid_nxt = sr_valid;
        or_load      = 1'b0;
        or_from_sr   = 1'b0;
        sr_load      = 1'b0;

        if (flush) begin
            or_valid_nxt = 1'b0;
            sr_valid_nxt = 1'b0;
        end else if (accept && (!or_valid || drain)) begin
            or_valid_nxt = 1'b1;
            or_load      = 1'b1;
            if (sr_valid) begin
                or_from_sr = 1'b1;
                sr_load    = 1'b1;
            end
        end else if (accept) begin
            sr_load      = 1'b1;
            sr_valid_nxt = 1'b1;
        end else if (drain) begin
            if (sr_valid) begin
                or_load      = 1'b1;
                or_from_sr   = 1'b1;
                sr_valid_nxt = 1'b0;
            end else begin
                or_valid_nxt = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            or_valid <= 1'b0;
            sr_valid <= 1'b0;
            ready_q  <= 1'b1;
            or_data  <= '0;
        end else begin
            or_valid <= or_valid_nxt;
            sr_valid <= sr_valid_nxt;
            ready_q  <= !sr_valid_nxt;
            if (or_load) or_data <= or_from_sr ? sr_data : in_data;
        end
    end

    // NOTE: SR payload is qualified by sr_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (sr_load) sr_data <= in_data;
    end

    assign in_ready  = ready_q;
    assign out_valid = or_valid;
    assign out_data  = or_data;
endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator between ID and EX: SEXT/ZEXT/LUI/BOFF modes into a skid buffer.
// Define IMM_BRANCH_TARGET_EN to add in_pc and a registered out_target = in_pc + BOFF result.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input logic               clk,
    input logic               reset_n,
    input logic               flush,
    imm_extend_pipe_if.slave  bus
);
    localparam bit WIDTHS_OK = imm_widths_ok(IN_W, OUT_W, SHIFT);

    generate
        if (!WIDTHS_OK) begin : g_bad_params
            $error("imm_extend_pipe: need 1 <= IN_W <= OUT_W and 0 <= SHIFT < OUT_W");
        end
    endgenerate

    logic [OUT_W-1:0] sext, zext, lui, boff, ext;

    // Width casts sign/zero extend without a zero-width replication when IN_W == OUT_W.
    always_comb begin
        sext = OUT_W'($signed(bus.in_imm));
        zext = OUT_W'(bus.in_imm);
        lui  = zext << (OUT_W - IN_W);
        boff = sext << SHIFT;
        case (bus.in_mode)
            SEXT:    ext = sext;
            ZEXT:    ext = zext;
            LUI:     ext = lui;
            BOFF:    ext = boff;
            default: ext = sext;
        endcase
    end

`ifdef IMM_BRANCH_TARGET_EN
    localparam int PW = 2 * OUT_W;
    logic [OUT_W-1:0] target;
    logic [PW-1:0]    payload_in, payload_out;

    // Target always uses the BOFF offset, whatever mode the decoder selected.
    assign target         = bus.in_pc + boff;
    assign payload_in     = {target, ext};
    assign bus.out_imm    = payload_out[OUT_W-1:0];
    assign bus.out_target = payload_out[PW-1:OUT_W];
`else
    localparam int PW = OUT_W;
    logic [PW-1:0] payload_in, payload_out;

    assign payload_in  = ext;
    assign bus.out_imm = payload_out;
`endif

    imm_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (payload_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (payload_out)
    );
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe: modes, backpressure, flush, reset, widths.
// Target-adder vectors run only when IMM_BRANCH_TARGET_EN is defined.
module tb_imm_extend_pipe;
    import imm_ext_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus   ();
    imm_extend_pipe_if #(.IN_W(12), .OUT_W(20)) bus_a ();
    imm_extend_pipe_if #(.IN_W(16), .OUT_W(16)) bus_b ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHIFT(2)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus)
    );
    imm_extend_pipe #(.IN_W(12), .OUT_W(20), .SHIFT(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus_a)
    );
    imm_extend_pipe #(.IN_W(16), .OUT_W(16), .SHIFT(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        n_checks++;
        if (bus.out_imm !== 32'h0) begin
            n_fail++; $display("FAIL reset_out_imm: got %h expected 00000000", bus.out_imm);
        end
`ifdef IMM_BRANCH_TARGET_EN
        n_checks++;
        if (bus.out_target !== 32'h0) begin
            n_fail++; $display("FAIL reset_out_target: got %h expected 00000000", bus.out_target);
        end
`endif
        #3 reset_n = 1'b1;
        step();
    endtask

    task automatic test_modes();
        logic [15:0] imm_v [4] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF};
        imm_mode_e   mode_v[4] = '{SEXT, ZEXT, LUI, BOFF};
        logic [31:0] exp_v [4] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_imm   = imm_v[i];
            bus.in_mode  = mode_v[i];
            step();
            n_checks++;
            if (bus.out_valid !== 1'b1) begin
                n_fail++; $display("FAIL mode%0d_latency: out_valid got %b expected 1", i, bus.out_valid);
            end
            n_checks++;
            if (bus.out_imm !== exp_v[i]) begin
                n_fail++; $display("FAIL mode%0d_value: got %h expected %h", i, bus.out_imm, exp_v[i]);
            end
        end
        bus.in_valid = 1'b0;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL modes_idle: out_valid got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] imm_v    [4] = '{16'h8000, 16'hF00F, 16'h00FF, 16'h0010};
        imm_mode_e   mode_v   [4] = '{SEXT, ZEXT, LUI, BOFF};
        logic [31:0] exp_v    [4] = '{32'hFFFF8000, 32'h0000F00F, 32'h00FF0000, 32'h00000040};
        bit          exp_ready[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int          sent = 0;
        int          got = 0;
        bit          started = 1'b0;
        bit          held = 1'b0;
        bit          acc, drn;
        logic [31:0] held_v = '0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            bus.out_ready = (cyc >= 3);
            bus.in_valid  = (sent < 4);
            if (sent < 4) begin
                bus.in_imm  = imm_v[sent];
                bus.in_mode = mode_v[sent];
            end
            if (cyc < 6) begin
                n_checks++;
                if (bus.in_ready !== exp_ready[cyc]) begin
                    n_fail++; $display("FAIL bp_in_ready_cyc%0d: got %b expected %b", cyc, bus.in_ready, exp_ready[cyc]);
                end
            end
            if (held) begin
                n_checks++;
                if (bus.out_imm !== held_v) begin
                    n_fail++; $display("FAIL bp_stall_stable_cyc%0d: got %h expected %h", cyc, bus.out_imm, held_v);
                end
            end
            acc = bus.in_valid && bus.in_ready;
            drn = bus.out_valid && bus.out_ready;
            if (started) begin
                n_checks++;
                if (!drn) begin
                    n_fail++; $display("FAIL bp_gap_cyc%0d: drain got 0 expected 1", cyc);
                end
            end
            if (drn) begin
                n_checks++;
                if (bus.out_imm !== exp_v[got]) begin
                    n_fail++; $display("FAIL bp_order_beat%0d: got %h expected %h", got, bus.out_imm, exp_v[got]);
                end
                got++;
                started = 1'b1;
            end
            held   = bus.out_valid && !bus.out_ready;
            held_v = bus.out_imm;
            step();
            if (acc) sent++;
        end
        n_checks++;
        if (got != 4) begin
            n_fail++; $display("FAIL bp_timeout: beats got %0d expected 4", got);
        end
        bus.in_valid = 1'b0;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drained: out_valid got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = SEXT;
        bus.in_imm    = 16'h0005;
        step();
        bus.in_imm    = 16'h0006;
        step();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_setup_full: in_ready got %b expected 0", bus.in_ready);
        end
        bus.in_imm = 16'h0007;
        flush      = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_full_out_valid: got %b expected 0", bus.out_valid);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_full_in_ready: got %b expected 1", bus.in_ready);
        end
        bus.out_ready = 1'b1;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_full_no_ghost: out_valid got %b expected 0", bus.out_valid);
        end
        // Empty pipe, ready high: the flush-cycle beat must still be dropped.
        bus.in_valid = 1'b1;
        bus.in_imm   = 16'h0008;
        flush        = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_wins_accept: out_valid got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = ZEXT;
        bus.in_imm    = 16'h1111;
        step();
        bus.in_imm    = 16'h2222;
        step();
        bus.in_valid  = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_setup: out_valid got %b expected 1", bus.out_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", bus.out_valid);
        end
        n_checks++;
        if (bus.out_imm !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_out_imm: got %h expected 00000000", bus.out_imm);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", bus.in_ready);
        end
        @(negedge clk);
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mode   = LUI;
        bus.in_imm    = 16'h0F0F;
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'h0F0F0000) begin
            n_fail++; $display("FAIL rstmid_first_beat: valid %b imm %h expected 1 0f0f0000", bus.out_valid, bus.out_imm);
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_no_stale: out_valid got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_params();
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        bus_a.in_valid  = 1'b1;
        bus_b.in_valid  = 1'b1;
        bus_a.in_mode   = BOFF;
        bus_a.in_imm    = 12'h800;
        bus_b.in_mode   = LUI;
        bus_b.in_imm    = 16'hABCD;
        step();
        n_checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_imm !== 20'hFF000) begin
            n_fail++; $display("FAIL w12_boff: valid %b imm %h expected 1 ff000", bus_a.out_valid, bus_a.out_imm);
        end
        n_checks++;
        if (bus_b.out_valid !== 1'b1 || bus_b.out_imm !== 16'hABCD) begin
            n_fail++; $display("FAIL w16_lui: valid %b imm %h expected 1 abcd", bus_b.out_valid, bus_b.out_imm);
        end
        bus_a.in_mode = SEXT;
        bus_b.in_mode = SEXT;
        bus_b.in_imm  = 16'h8000;
        step();
        n_checks++;
        if (bus_a.out_imm !== 20'hFF800) begin
            n_fail++; $display("FAIL w12_sext: got %h expected ff800", bus_a.out_imm);
        end
        n_checks++;
        if (bus_b.out_imm !== 16'h8000) begin
            n_fail++; $display("FAIL w16_sext: got %h expected 8000", bus_b.out_imm);
        end
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        step();
    endtask

`ifdef IMM_BRANCH_TARGET_EN
    task automatic test_target();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h00400004;
        bus.in_mode   = BOFF;
        bus.in_imm    = 16'h0003;
        step();
        n_checks++;
        if (bus.out_target !== 32'h00400010 || bus.out_imm !== 32'h0000000C) begin
            n_fail++; $display("FAIL target_boff: target %h imm %h expected 00400010 0000000c", bus.out_target, bus.out_imm);
        end
        bus.in_pc   = 32'hFFFFFFFC;
        bus.in_mode = SEXT;
        bus.in_imm  = 16'h0001;
        step();
        n_checks++;
        if (bus.out_target !== 32'h00000000 || bus.out_imm !== 32'h00000001) begin
            n_fail++; $display("FAIL target_wrap: target %h imm %h expected 00000000 00000001", bus.out_target, bus.out_imm);
        end
        bus.in_valid = 1'b0;
        step();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        flush           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_imm      = '0;
        bus.in_mode     = SEXT;
        bus.out_ready   = 1'b1;
        bus_a.in_valid  = 1'b0;
        bus_a.in_imm    = '0;
        bus_a.in_mode   = SEXT;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.in_imm    = '0;
        bus_b.in_mode   = SEXT;
        bus_b.out_ready = 1'b1;
`ifdef IMM_BRANCH_TARGET_EN
        bus.in_pc   = '0;
        bus_a.in_pc = '0;
        bus_b.in_pc = '0;
`endif
        test_reset();
        test_modes();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_params();
`ifdef IMM_BRANCH_TARGET_EN
        test_target();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
